// File: rtl/ctrl_api_pkg.sv
// Shared control-API definitions: message-type codes, tuser field offsets,
// route and FSM state enumerations used by the network-bridge splitter.
package ctrl_api_pkg;

  localparam int RPN_MSG_TYPE_WIDTH = 8;

  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_REQUEST = 8'h10;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_WRITE   = 8'h11;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_CHECK   = 8'h12;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_REQUEST = 8'h13;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_WRITE   = 8'h14;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_NUM_SEQ_NUM_CHECK        = 8'h15;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_SEQ_NUM_CHECK            = 8'h16;
  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY            = 8'h17;

  // tuser layout: {src port[63:48], dest port[47:32], IP[31:0]}
  localparam int TUSER_IP_LSB        = 0;
  localparam int TUSER_IP_W          = 32;
  localparam int TUSER_DEST_PORT_LSB = 32;
  localparam int TUSER_SRC_PORT_LSB  = 48;
  localparam int TUSER_PORT_W        = 16;

  typedef enum logic [1:0] {
    DROP     = 2'd0,
    OUT_REPO = 2'd1,
    IN_REPO  = 2'd2,
    SEQ_INIT = 2'd3
  } route_t;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_BODY  = 1'b1
  } state_t;

endpackage

// File: rtl/rpn_wnn_repo_from_network_bridge_splitter_if.sv
// AXI-Stream bundle used on every port of the splitter.
interface rpn_wnn_repo_from_network_bridge_splitter_if #(
  parameter int AXIS_DATA_WIDTH          = 512,
  parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 64
) ();
  logic                                tvalid;
  logic                                tready;
  logic [AXIS_DATA_WIDTH-1:0]          tdata;
  logic [AXIS_KEEP_WIDTH-1:0]          tkeep;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] tid;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] tdest;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] tuser;
  logic                                tlast;

  modport master (
    output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/rpn_wnn_repo_from_network_bridge_splitter_decoder.sv
// Combinational message-type to route decoder; unknown types map to DROP.
module rpn_msg_type_decoder
  import ctrl_api_pkg::*;
#(
  parameter int MSG_W = RPN_MSG_TYPE_WIDTH
) (
  input  logic [MSG_W-1:0] msg_type_i,
  output route_t           route_o
);

  // Map each known code to its destination repo.
  always_comb begin
    route_o = DROP;
    case (msg_type_i)
      MSG_W'(RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_REQUEST),
      MSG_W'(RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_WRITE),
      MSG_W'(RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_CHECK):   route_o = OUT_REPO;
      MSG_W'(RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_REQUEST),
      MSG_W'(RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_WRITE),
      MSG_W'(RPN_MSG_TYPE_WAN_NUM_SEQ_NUM_CHECK):        route_o = IN_REPO;
      MSG_W'(RPN_MSG_TYPE_WAN_SEQ_NUM_CHECK),
      MSG_W'(RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY):            route_o = SEQ_INIT;
      default:                                           route_o = DROP;
    endcase
  end

endmodule

// File: rtl/rpn_wnn_repo_from_network_bridge_splitter.sv
// Zero-latency AXIS splitter: routes each packet from the network bridge to
// one of three repos by the message type carried in its first beat. Payload
// is broadcast; only tvalid is gated and tready is muxed from the selection.
module rpn_wnn_repo_from_network_bridge_splitter #(
  parameter int AXIS_DATA_WIDTH          = 512,
  parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 64,
  parameter int RPN_MSG_TYPE_WIDTH       = ctrl_api_pkg::RPN_MSG_TYPE_WIDTH
) (
  input  logic i_clk,
  input  logic i_ap_rst_n,
  rpn_wnn_repo_from_network_bridge_splitter_if.slave  from_network_bridge,
  rpn_wnn_repo_from_network_bridge_splitter_if.master to_rpn_WNN_outgoing_repo,
  rpn_wnn_repo_from_network_bridge_splitter_if.master to_rpn_WNN_incoming_repo,
  rpn_wnn_repo_from_network_bridge_splitter_if.master to_rpn_WAN_seq_num_initializer
);
  import ctrl_api_pkg::*;

  logic [AXIS_DATA_WIDTH-1:0]          fwd_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]          fwd_tkeep;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] fwd_tid;
  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] fwd_tdest;
  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] fwd_tuser;
  logic                                fwd_tlast;

  state_t state_q, state_d;
  route_t route_q, route_d;
  route_t route_dec;
  route_t route_sel;
  logic   in_ready;
  logic   out_vld, in_vld, seq_vld;
  logic   hs;

  assign fwd_tdata = from_network_bridge.tdata;
  assign fwd_tkeep = from_network_bridge.tkeep;
  assign fwd_tid   = from_network_bridge.tid;
  assign fwd_tdest = from_network_bridge.tdest;
  assign fwd_tuser = from_network_bridge.tuser;
  assign fwd_tlast = from_network_bridge.tlast;

  rpn_msg_type_decoder #(
    .MSG_W (RPN_MSG_TYPE_WIDTH)
  ) u_decoder (
    .msg_type_i (fwd_tdata[RPN_MSG_TYPE_WIDTH-1:0]),
    .route_o    (route_dec)
  );

  // Route selection, tvalid gating, tready mux and packet-framing next state.
  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    route_sel = route_q;
    in_ready  = 1'b0;
    out_vld   = 1'b0;
    in_vld    = 1'b0;
    seq_vld   = 1'b0;
    hs        = 1'b0;

    // First beat decodes live tdata; body beats reuse the latched route.
    if (state_q == ST_FIRST) begin
      route_sel = route_dec;
    end

    case (route_sel)
      OUT_REPO: begin
        out_vld  = from_network_bridge.tvalid;
        in_ready = to_rpn_WNN_outgoing_repo.tready;
      end
      IN_REPO: begin
        in_vld   = from_network_bridge.tvalid;
        in_ready = to_rpn_WNN_incoming_repo.tready;
      end
      SEQ_INIT: begin
        seq_vld  = from_network_bridge.tvalid;
        in_ready = to_rpn_WAN_seq_num_initializer.tready;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase

    // Nothing moves while reset is held, including the combinational paths.
    if (!i_ap_rst_n) begin
      in_ready = 1'b0;
      out_vld  = 1'b0;
      in_vld   = 1'b0;
      seq_vld  = 1'b0;
    end

    hs = from_network_bridge.tvalid && in_ready;

    case (state_q)
      ST_FIRST: begin
        if (hs && !fwd_tlast) begin
          state_d = ST_BODY;
          route_d = route_dec;
        end
      end
      default: begin
        if (hs && fwd_tlast) begin
          state_d = ST_FIRST;
        end
      end
    endcase
  end

  // State and latched route; reset aborts any packet in flight.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state_q <= ST_FIRST;
      route_q <= DROP;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  assign from_network_bridge.tready = in_ready;

  assign to_rpn_WNN_outgoing_repo.tvalid = out_vld;
  assign to_rpn_WNN_outgoing_repo.tdata  = fwd_tdata;
  assign to_rpn_WNN_outgoing_repo.tkeep  = fwd_tkeep;
  assign to_rpn_WNN_outgoing_repo.tid    = fwd_tid;
  assign to_rpn_WNN_outgoing_repo.tdest  = fwd_tdest;
  assign to_rpn_WNN_outgoing_repo.tuser  = fwd_tuser;
  assign to_rpn_WNN_outgoing_repo.tlast  = fwd_tlast;

  assign to_rpn_WNN_incoming_repo.tvalid = in_vld;
  assign to_rpn_WNN_incoming_repo.tdata  = fwd_tdata;
  assign to_rpn_WNN_incoming_repo.tkeep  = fwd_tkeep;
  assign to_rpn_WNN_incoming_repo.tid    = fwd_tid;
  assign to_rpn_WNN_incoming_repo.tdest  = fwd_tdest;
  assign to_rpn_WNN_incoming_repo.tuser  = fwd_tuser;
  assign to_rpn_WNN_incoming_repo.tlast  = fwd_tlast;

  assign to_rpn_WAN_seq_num_initializer.tvalid = seq_vld;
  assign to_rpn_WAN_seq_num_initializer.tdata  = fwd_tdata;
  assign to_rpn_WAN_seq_num_initializer.tkeep  = fwd_tkeep;
  assign to_rpn_WAN_seq_num_initializer.tid    = fwd_tid;
  assign to_rpn_WAN_seq_num_initializer.tdest  = fwd_tdest;
  assign to_rpn_WAN_seq_num_initializer.tuser  = fwd_tuser;
  assign to_rpn_WAN_seq_num_initializer.tlast  = fwd_tlast;

endmodule

// File: tb/tb_rpn_wnn_repo_from_network_bridge_splitter.sv
// Directed bench for the network-bridge splitter: a vector table of single
// beat routing cases plus hand-written multi-beat, re-route and reset cases.
module tb_rpn_wnn_repo_from_network_bridge_splitter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rpn_wnn_repo_from_network_bridge_splitter_if nb ();
  rpn_wnn_repo_from_network_bridge_splitter_if outr ();
  rpn_wnn_repo_from_network_bridge_splitter_if inr ();
  rpn_wnn_repo_from_network_bridge_splitter_if seqr ();

  rpn_wnn_repo_from_network_bridge_splitter dut (
    .i_clk                          (clk),
    .i_ap_rst_n                     (rst_n),
    .from_network_bridge            (nb),
    .to_rpn_WNN_outgoing_repo       (outr),
    .to_rpn_WNN_incoming_repo       (inr),
    .to_rpn_WAN_seq_num_initializer (seqr)
  );

  typedef struct {
    logic [7:0] typ;
    logic       v, l;
    logic       ro, ri, rs;
    logic       eo, ei, es, er;
  } vec_t;

  vec_t vecs [13];

  logic [503:0] data_hi;
  logic [63:0]  tuser_pat;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] t, input logic v, input logic l,
                       input logic ro, input logic ri, input logic rs);
    nb.tdata    = {data_hi, t};
    nb.tkeep    = '1;
    nb.tid      = 8'hAB;
    nb.tdest    = 8'hAB;
    nb.tuser    = tuser_pat;
    nb.tlast    = l;
    nb.tvalid   = v;
    outr.tready = ro;
    inr.tready  = ri;
    seqr.tready = rs;
  endtask

  task automatic chk_ports(input string nm, input logic eo, input logic ei,
                           input logic es, input logic er);
    chk({nm, ".out_vld"}, 512'(outr.tvalid), 512'(eo));
    chk({nm, ".in_vld"},  512'(inr.tvalid),  512'(ei));
    chk({nm, ".seq_vld"}, 512'(seqr.tvalid), 512'(es));
    chk({nm, ".ready"},   512'(nb.tready),   512'(er));
  endtask

  task automatic chk_fwd(input string nm, input int sel, input logic [7:0] t);
    logic [511:0] d;
    logic [63:0]  u;
    logic [7:0]   id, dst;
    logic [63:0]  k;
    logic         lst;
    case (sel)
      0: begin d = outr.tdata; u = outr.tuser; id = outr.tid; dst = outr.tdest; k = outr.tkeep; lst = outr.tlast; end
      1: begin d = inr.tdata;  u = inr.tuser;  id = inr.tid;  dst = inr.tdest;  k = inr.tkeep;  lst = inr.tlast;  end
      default: begin d = seqr.tdata; u = seqr.tuser; id = seqr.tid; dst = seqr.tdest; k = seqr.tkeep; lst = seqr.tlast; end
    endcase
    chk({nm, ".tdata"}, d, {data_hi, t});
    chk({nm, ".tuser"}, 512'(u), 512'({16'hACAC, 16'hBBBB, 32'h0C0D0E0F}));
    chk({nm, ".tid"},   512'(id), 512'(8'hAB));
    chk({nm, ".tdest"}, 512'(dst), 512'(8'hAB));
    chk({nm, ".tkeep"}, 512'(k), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    chk({nm, ".tlast"}, 512'(lst), 512'(1'b1));
  endtask

  initial begin
    data_hi   = {63{8'h5A}};
    tuser_pat = {16'hACAC, 16'hBBBB, 32'h0C0D0E0F};

    //            typ    v     l     ro    ri    rs    eo    ei    es    er
    vecs[0]  = '{8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'h14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{8'h16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'h18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state with a live, ready-everywhere beat presented.
    rst_n = 1'b0;
    drive(8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #3;
    chk_ports("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single-beat vector table.
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #2 drive(vecs[i].typ, vecs[i].v, vecs[i].l, vecs[i].ro, vecs[i].ri, vecs[i].rs);
      #1 chk_ports($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ei, vecs[i].es, vecs[i].er);
    end

    // Sweep all eight codes, toggling the selected port's tready mid-cycle.
    for (int c = 0; c < 8; c++) begin
      logic [7:0] t;
      int         sel;
      logic       so, si, ss;
      t   = 8'h10 + 8'(c);
      sel = (c < 3) ? 0 : (c < 6) ? 1 : 2;
      so  = (sel == 0);
      si  = (sel == 1);
      ss  = (sel == 2);
      @(posedge clk);
      #1 drive(t, 1'b1, 1'b1, so, si, ss);
      #1 chk_ports($sformatf("sweep%0h_rdy1", t), so, si, ss, 1'b1);
      #2 drive(t, 1'b1, 1'b1, ~so, ~si, ~ss);
      #1 chk_ports($sformatf("sweep%0h_rdy0", t), so, si, ss, 1'b0);
      chk_fwd($sformatf("sweep%0h", t), sel, t);
    end

    // Multi-beat unknown type: whole packet consumed, body type bits ignored.
    @(posedge clk);
    #2 drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_ports("drop_b1", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk_ports("drop_b2", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk_ports("drop_b3", 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk_ports("drop_next", 1'b1, 1'b0, 1'b0, 1'b1);

    // 3-beat incoming-repo packet with body type 0x10 and one stall.
    @(posedge clk);
    #2 drive(8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk_ports("pkt_b1", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk_ports("pkt_stall", 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 drive(8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk_ports("pkt_b2", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk_ports("pkt_b3", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #1 chk_ports("pkt_next", 1'b0, 1'b0, 1'b1, 1'b1);

    // Type change without handshake re-routes immediately on a first beat.
    @(posedge clk);
    #2 drive(8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_ports("reroute_a", 1'b1, 1'b0, 1'b0, 1'b0);
    #2 drive(8'h13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_ports("reroute_b", 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2 drive(8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during beat 2 of a 3-beat packet aborts it.
    @(posedge clk);
    #2 drive(8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 chk_ports("rst_b1", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 chk_ports("rst_b2", 1'b0, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_ports("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 chk_ports("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    drive(8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk_ports("rst_after", 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rpn_wnn_repo_from_network_bridge_splitter.md
RPN_WNN_REPO_FROM_NETWORK_BRIDGE_SPLITTER -- requirements
Module: rpn_WNN_repo_from_network_bridge_splitter

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 512: tdata width.
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8: tkeep width.
REQ-003 SHALL have parameter AXIS_FROM_NB_TDEST_WIDTH, default 8: tid/tdest width, used for both tid and tdest.
REQ-004 SHALL have parameter AXIS_FROM_NB_TUSER_WIDTH, default 64: tuser width, carrying {src port[63:48], dest port[47:32], IP[31:0]}.
REQ-005 SHALL have parameter RPN_MSG_TYPE_WIDTH, default 8: message-type field at tdata[RPN_MSG_TYPE_WIDTH-1:0].
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-007 i_clk  input  1  clock.
REQ-008 i_ap_rst_n  input  1  asynchronous active-low reset.
REQ-009 from_network_bridge_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}  slave AXIS  1/1/DATA/KEEP/TDEST/TDEST/TUSER/1  ingress from network bridge; tready is an output.
REQ-010 to_rpn_WNN_outgoing_repo_{same 8 signals}  master AXIS  same widths  WNN outgoing repo; tready is an input.
REQ-011 to_rpn_WNN_incoming_repo_{same 8 signals}  master AXIS  same widths  WNN incoming repo.
REQ-012 to_rpn_WAN_seq_num_initializer_{same 8 signals}  master AXIS  same widths  WAN sequence-number initializer.

Function
REQ-013 Routing by msg type on the first beat of a packet, as follows.
REQ-014 WAN_OUTGOING_SEQ_NUM_REQUEST/WRITE/CHECK -> outgoing repo.
REQ-015 WAN_INCOMING_SEQ_NUM_REQUEST/WRITE and WAN_NUM_SEQ_NUM_CHECK -> incoming repo.
REQ-016 WAN_SEQ_NUM_CHECK/REPLY -> seq num initializer.
REQ-017 Any other type is dropped: ingress tready=1, no output valid, and the whole packet is consumed through tlast.
REQ-018 Zero-latency combinational datapath: the selected port's tvalid equals ingress tvalid, and the other ports' tvalid=0.
REQ-019 tdata/tkeep/tid/tdest/tuser/tlast SHALL be forwarded unmodified to all three ports; only tvalid is gated.
REQ-020 Ingress tready equals the selected port's tready, combinationally; tready changes mid-cycle propagate immediately, and non-selected port treadys are ignored.
REQ-021 Two-state FSM: FIRST and BODY.
  - In FIRST, the route is decoded from current tdata.
  - A handshake with tlast=0 latches the route and moves to BODY.
  - In BODY, the latched route is used, ignoring tdata type bits.
  - A handshake with tlast=1 returns to FIRST.
REQ-022 Single-beat packets (tlast=1) never leave FIRST.
REQ-023 A type change while tvalid is held without handshake SHALL re-route immediately in FIRST; masters are expected to hold data, but no lock is applied before the first handshake.
REQ-024 No buffering: backpressure on the selected port stalls the ingress; other ports are unaffected.

Reset
REQ-025 While i_ap_rst_n=0: all output tvalid=0, ingress tready=0, FSM=FIRST, latched route cleared (drop).
REQ-026 Reset asserted mid-packet SHALL abort the packet; the next beat after release is treated as a first beat.

Structure
REQ-027 Shared package ctrl_api_pkg SHALL hold RPN_MSG_TYPE_WIDTH, the eight RPN_MSG_TYPE_* codes (WAN_OUTGOING_SEQ_NUM_REQUEST=0x10, _WRITE=0x11, _CHECK=0x12, WAN_INCOMING_SEQ_NUM_REQUEST=0x13, _WRITE=0x14, WAN_NUM_SEQ_NUM_CHECK=0x15, WAN_SEQ_NUM_CHECK=0x16, WAN_SEQ_NUM_REPLY=0x17), the tuser offsets, and a route_t enum {DROP, OUT_REPO, IN_REPO, SEQ_INIT}.
REQ-028 One sub-module is natural: rpn_msg_type_decoder, a combinational type-to-route_t decoder.

Verification
REQ-029 Type 0x10, tvalid=1, tlast=1, outgoing tready=1 -> outgoing tvalid=1, others 0, ingress tready=1.
  - Same beat with outgoing tready=0, others 1 -> ingress tready=0.
REQ-030 Sweep all eight codes with the selected port's tready toggled every half-cycle.
  - Ingress tready tracks only the selected port.
  - tdata/tuser (IP 0x0C0D0E0F, dest port 0xBBBB, src port 0xACAC), tid 0xAB and tdest 0xAB appear unchanged on the selected port.
REQ-031 Type 0x00 -> no output tvalid; ingress tready=1; the packet is consumed.
REQ-032 3-beat packet: first beat type 0x13, later beats with type bits 0x10.
  - All beats go to the incoming repo.
  - The next packet, 0x16, goes to the seq num initializer.
REQ-033 Reset (i_ap_rst_n=0) during beat 2 of a 3-beat packet.
  - All tvalid=0 and tready=0 during reset.
  - After release, type 0x11 routes to the outgoing repo.
